// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU add scheduler: data width, FSM encoding and flag mask.
package fpu_pkg;

  // IEEE-754 single-precision operand/result width.
  localparam int unsigned XLEN = 32;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // Width of the adder flag vector {exc, unf, ovf}.
  localparam int unsigned FlagW = 3;

  // Flags that fold into rsp_exc; ordered {exc, unf, ovf}.
  localparam logic [FlagW-1:0] FlagMask = 3'b111;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the priority pointer.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IdxW-1:0] gnt_idx
);

  // Scan from ptr upward, wrapping modulo NREQ; first active request wins.
  always_comb begin
    int unsigned idx;
    logic [IdxW-1:0] sel;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      sel = IdxW'(idx);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/fpu_add_scheduler.sv
// Shares one external floating-point adder among NREQ requesters with round-robin arbitration.
module fpu_add_scheduler
  import fpu_pkg::*;
#(
  parameter int unsigned XLEN    = fpu_pkg::XLEN,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]      rsp_data,
  output logic                 rsp_exc,
  output logic [XLEN-1:0]      add_a,
  output logic [XLEN-1:0]      add_b,
  input  logic [XLEN-1:0]      add_result,
  input  logic                 add_ovf,
  input  logic                 add_unf,
  input  logic                 add_exc,
  output logic                 busy
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // ADD_LAT is at most 4, so the countdown never exceeds 3.
  localparam int unsigned CntW = 2;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] add_a_q, add_a_d;
  logic [XLEN-1:0] add_b_q, add_b_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_exc_q, rsp_exc_d;

  logic [NREQ-1:0] gnt;
  logic [IdxW-1:0] gnt_idx;
  logic [XLEN-1:0] sel_a, sel_b;
  logic [NREQ-1:0] owner_oh;

  rr_arbiter #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Select the granted requester's operand pair.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IdxW'(i)) begin
        sel_a = req_a[i*XLEN +: XLEN];
        sel_b = req_b[i*XLEN +: XLEN];
      end
    end
  end

  assign owner_oh = NREQ'(1) << owner_q;

  // Next-state logic, handshakes and capture of operands/results.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    rsp_data_d = rsp_data_q;
    rsp_exc_d  = rsp_exc_q;
    req_ready  = '0;
    unique case (state_q)
      StIdle: begin
        // Grant is only offered outside reset so req_ready reads zero while rst is high.
        if (!rst && (|gnt)) begin
          req_ready = gnt;
          add_a_d   = sel_a;
          add_b_d   = sel_b;
          owner_d   = gnt_idx;
          ptr_d     = (gnt_idx == IdxW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = CntW'(ADD_LAT - 1);
        state_d = StWait;
      end
      StWait: begin
        // Counter at zero marks the cycle the adder output is valid.
        if (cnt_q == '0) begin
          rsp_data_d = add_result;
          rsp_exc_d  = |({add_exc, add_unf, add_ovf} & FlagMask);
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        // Only the owner's rsp_ready completes the response.
        if (|(rsp_ready & owner_oh)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      rsp_data_q <= '0;
      rsp_exc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_exc_q  <= rsp_exc_d;
    end
  end

  assign rsp_valid = (state_q == StResp) ? owner_oh : '0;
  assign rsp_data  = rsp_data_q;
  assign rsp_exc   = rsp_exc_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fpu_add_scheduler.sv
// Self-checking bench for fpu_add_scheduler with a pipelined adder model and round-robin model.
module tb_fpu_add_scheduler;

  localparam int NREQ    = 4;
  localparam int XLEN    = 32;
  localparam int ADD_LAT = 4;
  localparam int AW      = NREQ * XLEN;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [AW-1:0]   req_a, req_b;
  logic [XLEN-1:0] rsp_data, add_a, add_b, add_result;
  logic            rsp_exc, add_ovf, add_unf, add_exc, busy;

  int checks   = 0;
  int failures = 0;
  int exp_ptr  = 0;

  always #5 clk = ~clk;

  fpu_add_scheduler #(
    .XLEN    (XLEN),
    .NREQ    (NREQ),
    .ADD_LAT (ADD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_exc    (rsp_exc),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .add_ovf    (add_ovf),
    .add_unf    (add_unf),
    .add_exc    (add_exc),
    .busy       (busy)
  );

  // Adder behaviour: {exc, unf, ovf, sum}. Two fixed IEEE cases, otherwise a scrambling hash.
  function automatic logic [XLEN+2:0] add_model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] h;
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return {3'b000, 32'h4040_0000};
    if (a == 32'h7F00_0000 && b == 32'h7F00_0000) return {3'b001, 32'h7F80_0000};
    h = a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0F0F;
    return {h[9] & h[8], h[7] & h[6], h[5] & h[4], h + b};
  endfunction

  // Adder pipeline: output valid ADD_LAT cycles after operands are presented.
  logic [XLEN+2:0] pipe [ADD_LAT];
  always @(posedge clk) begin
    pipe[0] <= add_model(add_a, add_b);
    for (int k = 1; k < ADD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign {add_exc, add_unf, add_ovf, add_result} = pipe[ADD_LAT-1];

  // Round-robin reference: first active requester at or after p, modulo NREQ.
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (p + i) % NREQ;
      if (((v >> idx) & NREQ'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] rand_ops();
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) r = (r << XLEN) | AW'($urandom);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (ADD_LAT + 2) step();
    rst     = 1'b0;
    exp_ptr = 0;
  endtask

  // One full operation from the current IDLE cycle; caller drives req_valid/req_a/req_b first.
  task automatic run_op(input int hold, input bit churn, output int owner);
    int g;
    logic [XLEN-1:0] ea, eb;
    logic [XLEN+2:0] er;
    logic [NREQ-1:0] oh;
    #1;
    g     = pick(req_valid, exp_ptr);
    owner = g;
    oh    = (g >= 0) ? (NREQ'(1) << g) : '0;
    checks++;
    if (req_ready !== oh) begin
      failures++;
      $display("FAIL grant: req_ready=%b expected=%b", req_ready, oh);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy: busy=%b expected=0", busy);
    end
    if (g < 0) return;
    ea = XLEN'(req_a >> (g * XLEN));
    eb = XLEN'(req_b >> (g * XLEN));
    er = add_model(ea, eb);
    rsp_ready = NREQ'($urandom) & ~oh;
    step();
    // ISSUE plus ADD_LAT WAIT cycles: no response, operands held.
    for (int c = 1; c <= ADD_LAT + 1; c++) begin
      if (churn) begin
        req_valid = NREQ'($urandom);
        req_a     = rand_ops();
        req_b     = rand_ops();
      end
      #1;
      checks++;
      if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_phase c=%0d: req_ready=%b rsp_valid=%b busy=%b expected 0000/0000/1",
                 c, req_ready, rsp_valid, busy);
      end
      checks++;
      if (add_a !== ea || add_b !== eb) begin
        failures++;
        $display("FAIL operand_hold c=%0d: add_a=%h add_b=%h expected %h %h", c, add_a, add_b,
                 ea, eb);
      end
      step();
    end
    // RESP: stall hold cycles (non-owners may be ready), then owner accepts.
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold) ? (NREQ'($urandom) | oh) : (NREQ'($urandom) & ~oh);
      #1;
      checks++;
      if (rsp_valid !== oh || rsp_data !== er[XLEN-1:0] || rsp_exc !== (|er[XLEN+2:XLEN])) begin
        failures++;
        $display("FAIL response h=%0d: rsp_valid=%b data=%h exc=%b expected %b %h %b", h,
                 rsp_valid, rsp_data, rsp_exc, oh, er[XLEN-1:0], |er[XLEN+2:XLEN]);
      end
      checks++;
      if (req_ready !== '0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL resp_phase h=%0d: req_ready=%b busy=%b expected 0000/1", h, req_ready, busy);
      end
      step();
    end
    rsp_ready = '0;
    exp_ptr   = (g + 1) % NREQ;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin
      failures++;
      $display("FAIL back_to_idle: busy=%b rsp_valid=%b expected 0/0000", busy, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    req_a     = rand_ops();
    req_b     = rand_ops();
    repeat (ADD_LAT + 2) step();
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0 || rsp_exc !== 1'b0 ||
        add_a !== '0 || add_b !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: rdy=%b vld=%b data=%h exc=%b a=%h b=%h busy=%b expected all 0",
               req_ready, rsp_valid, rsp_data, rsp_exc, add_a, add_b, busy);
    end
    req_valid = '0;
    rst       = 1'b0;
    exp_ptr   = 0;
    step();
    checks++;
    if (req_ready !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_request: req_ready=%b busy=%b expected 0000/0", req_ready, busy);
    end
  endtask

  task automatic test_single();
    int o;
    do_reset();
    req_valid              = 4'b0001;
    req_a[XLEN-1:0]        = 32'h3F80_0000;
    req_b[XLEN-1:0]        = 32'h4000_0000;
    run_op(0, 1'b0, o);
    checks++;
    if (o !== 0 || rsp_data !== 32'h4040_0000 || rsp_exc !== 1'b0) begin
      failures++;
      $display("FAIL single_add: owner=%0d data=%h exc=%b expected 0 40400000 0", o, rsp_data,
               rsp_exc);
    end
  endtask

  task automatic test_fairness();
    int o;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_valid = '1;
    rsp_ready = '1;
    for (int n = 0; n < 5; n++) begin
      req_a = rand_ops();
      req_b = rand_ops();
      run_op(0, 1'b0, o);
      checks++;
      if (o !== exp_order[n]) begin
        failures++;
        $display("FAIL fairness n=%0d: granted=%0d expected=%0d", n, o, exp_order[n]);
      end
    end
  endtask

  task automatic test_backpressure();
    int o;
    req_valid = 4'b0110;
    req_a     = rand_ops();
    req_b     = rand_ops();
    run_op(5, 1'b0, o);
  endtask

  task automatic test_flag();
    int o;
    req_valid                 = 4'b0010;
    req_a[2*XLEN-1:XLEN]      = 32'h7F00_0000;
    req_b[2*XLEN-1:XLEN]      = 32'h7F00_0000;
    run_op(1, 1'b0, o);
    checks++;
    if (rsp_data !== 32'h7F80_0000 || rsp_exc !== 1'b1) begin
      failures++;
      $display("FAIL overflow_flag: data=%h exc=%b expected 7f800000 1", rsp_data, rsp_exc);
    end
  endtask

  task automatic test_reset_mid_wait();
    int o;
    req_valid = 4'b0100;
    req_a     = rand_ops();
    req_b     = rand_ops();
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL abort_grant: req_ready=%b expected=0100", req_ready);
    end
    step();  // accept -> ISSUE
    step();  // WAIT cycle 1
    step();  // WAIT cycle 2
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0 || rsp_exc !== 1'b0 ||
        add_a !== '0 || add_b !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset: rdy=%b vld=%b data=%h exc=%b a=%h b=%h busy=%b expected all 0",
               req_ready, rsp_valid, rsp_data, rsp_exc, add_a, add_b, busy);
    end
    for (int c = 0; c < ADD_LAT + 3; c++) begin
      step();
      checks++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_rsp c=%0d: rsp_valid=%b busy=%b expected 0000/0", c, rsp_valid,
                 busy);
      end
    end
    rsp_ready = '0;
    exp_ptr   = 0;
    req_valid = '1;
    req_a     = rand_ops();
    req_b     = rand_ops();
    run_op(0, 1'b0, o);
    checks++;
    if (o !== 0) begin
      failures++;
      $display("FAIL abort_pointer: granted=%0d expected=0", o);
    end
  endtask

  task automatic test_wrap();
    int o;
    do_reset();
    req_valid = 4'b1000;
    req_a     = rand_ops();
    req_b     = rand_ops();
    run_op(0, 1'b0, o);
    req_valid = '1;
    run_op(0, 1'b0, o);
    checks++;
    if (o !== 0) begin
      failures++;
      $display("FAIL wrap: granted=%0d expected=0", o);
    end
  endtask

  task automatic test_random();
    int o;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== '0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL idle_gap n=%0d: req_ready=%b busy=%b expected 0000/0", n, req_ready,
                   busy);
        end
        step();
      end
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req_a     = rand_ops();
      req_b     = rand_ops();
      run_op($urandom_range(0, 3), 1'b1, o);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_flag();
    test_reset_mid_wait();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
